// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: synchronises the async SCK/WS/SD lines into s2_clk,
// deserialises one MSB-first word per WS slot and presents it sign-extended to 32 bits.
module i2s_mic_rx #(
    parameter int unsigned DATA_BITS   = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        s2_clk,
    input  logic        s2_reset,
    input  logic        enable,
    input  logic        i2s_sck,
    input  logic        i2s_ws,
    input  logic        i2s_sd,
    output logic [31:0] sample_aud,
    output logic        sample_ready,
    output logic        sample_chan,
    output logic        frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sck_s;
    logic                   ws_s;
    logic                   sd_s;
    logic                   sck_prev;
    logic                   sck_rise;
    logic                   ws_prev;
    logic                   ws_edge;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   slot_chan;
    logic                   word_done;

    // Identical synchroniser chains keep SCK, WS and SD mutually aligned
    always_ff @(posedge s2_clk) begin
        if (s2_reset) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign ws_edge  = sck_rise & (ws_s != ws_prev);

    // Slot FSM; the completed word is published one cycle after entering WAIT
    always_ff @(posedge s2_clk) begin
        if (s2_reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            sck_prev     <= 1'b0;
            ws_prev      <= 1'b0;
            slot_chan    <= 1'b0;
            word_done    <= 1'b0;
            sample_aud   <= 32'h0;
            sample_ready <= 1'b0;
            sample_chan  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_ready <= 1'b0;
            frame_err    <= 1'b0;
            word_done    <= 1'b0;
            sck_prev     <= sck_s;

            // WS history tracks the line even while disabled, so re-enable waits for a real edge
            if (sck_rise) begin
                ws_prev <= ws_s;
            end

            if (word_done && enable) begin
                sample_aud   <= 32'($signed(shift_q));
                sample_chan  <= slot_chan;
                sample_ready <= 1'b1;
            end

            if (!enable) begin
                state <= IDLE;
            end else if (sck_rise) begin
                case (state)
                    IDLE: begin
                        if (ws_edge) begin
                            bit_cnt   <= '0;
                            slot_chan <= ws_s;
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // The WS-edge bit is the previous slot's LSB and is never shifted
                        if (ws_edge) begin
                            bit_cnt   <= '0;
                            slot_chan <= ws_s;
                            frame_err <= 1'b1;
                        end else begin
                            shift_q <= {shift_q[DATA_BITS-2:0], sd_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                                state     <= WAIT;
                                word_done <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (ws_edge) begin
                            bit_cnt   <= '0;
                            slot_chan <= ws_s;
                            state     <= SHIFT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx: 24-bit and 32-bit instances share one I2S bus,
// SCK runs at s2_clk/16.
module tb_i2s_mic_rx;

    logic        s2_clk   = 1'b0;
    logic        s2_reset = 1'b1;
    logic        enable   = 1'b1;
    logic        i2s_sck  = 1'b0;
    logic        i2s_ws   = 1'b1;
    logic        i2s_sd   = 1'b0;

    logic [31:0] aud24;
    logic        rdy24;
    logic        chan24;
    logic        err24;
    logic [31:0] aud32;
    logic        rdy32;
    logic        chan32;
    logic        err32;

    int n_pass    = 0;
    int n_checks  = 0;
    int cyc       = 0;
    int rise_cyc  = 0;
    int last_rise = 0;
    int rdy24_n   = 0;
    int err24_n   = 0;
    int rdy32_n   = 0;
    int err32_n   = 0;
    int rdy24_cyc = 0;
    int r0;
    int e0;

    i2s_mic_rx #(.DATA_BITS(24), .SYNC_STAGES(2)) dut24 (
        .s2_clk      (s2_clk),
        .s2_reset    (s2_reset),
        .enable      (enable),
        .i2s_sck     (i2s_sck),
        .i2s_ws      (i2s_ws),
        .i2s_sd      (i2s_sd),
        .sample_aud  (aud24),
        .sample_ready(rdy24),
        .sample_chan (chan24),
        .frame_err   (err24)
    );

    i2s_mic_rx #(.DATA_BITS(32), .SYNC_STAGES(2)) dut32 (
        .s2_clk      (s2_clk),
        .s2_reset    (s2_reset),
        .enable      (enable),
        .i2s_sck     (i2s_sck),
        .i2s_ws      (i2s_ws),
        .i2s_sd      (i2s_sd),
        .sample_aud  (aud32),
        .sample_ready(rdy32),
        .sample_chan (chan32),
        .frame_err   (err32)
    );

    always #5 s2_clk = ~s2_clk;

    always @(posedge s2_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Pulse monitor: every high cycle counts, so a stretched pulse shows up as an extra count
    always @(negedge s2_clk) begin
        if (rdy24) begin
            rdy24_n++;
            rdy24_cyc = cyc;
        end
        if (err24) err24_n++;
        if (rdy32) rdy32_n++;
        if (err32) err32_n++;
        if (rdy24 || err24) check("excl24", 32'(rdy24 & err24), 32'd0);
        if (rdy32 || err32) check("excl32", 32'(rdy32 & err32), 32'd0);
    end

    // One SCK period: WS/SD set while SCK is low, 8 clk low then 8 clk high
    task automatic sck_bit(input logic ws_v, input logic sd_v);
        @(negedge s2_clk);
        i2s_ws = ws_v;
        i2s_sd = sd_v;
        repeat (7) @(negedge s2_clk);
        i2s_sck  = 1'b1;
        rise_cyc = cyc;
        repeat (8) @(negedge s2_clk);
        i2s_sck = 1'b0;
    endtask

    // Slot of len SCKs: edge bit (SD=0), nbits MSB-first data, zero padding
    task automatic send_slot(input logic ws_v, input logic [31:0] word, input int nbits,
                             input int len, input int en_flip_at);
        for (int i = 0; i < len; i++) begin
            logic b;
            b = (i >= 1 && i <= nbits) ? word[nbits - i] : 1'b0;
            if (i == en_flip_at) enable = ~enable;
            sck_bit(ws_v, b);
            if (i == nbits) last_rise = rise_cyc;
        end
    endtask

    initial begin
        logic [31:0] w;

        repeat (3) @(negedge s2_clk);
        check("rst_aud", aud24, 32'h0);
        check("rst_rdy", 32'(rdy24), 32'd0);
        check("rst_chan", 32'(chan24), 32'd0);
        check("rst_err", 32'(err24), 32'd0);
        check("rst_aud32", aud32, 32'h0);
        s2_reset = 1'b0;

        // Opening right slot
        r0 = rdy24_n;
        send_slot(1'b1, 32'h123456, 24, 32, -1);
        check("pre_cnt", 32'(rdy24_n - r0), 32'd1);
        check("pre_aud", aud24, 32'h00123456);
        check("pre_chan", 32'(chan24), 32'd1);

        // Left slot, negative word, latency from the 24th SCK rise
        r0 = rdy24_n;
        send_slot(1'b0, 32'hFFF84C, 24, 32, -1);
        check("s1_cnt", 32'(rdy24_n - r0), 32'd1);
        check("s1_aud", aud24, 32'hFFFFF84C);
        check("s1_chan", 32'(chan24), 32'd0);
        check("s1_lat", 32'(rdy24_cyc - last_rise), 32'd4);

        // Full-scale positive right, full-scale negative left
        send_slot(1'b1, 32'h7FFFFF, 24, 32, -1);
        check("s2r_aud", aud24, 32'h007FFFFF);
        check("s2r_chan", 32'(chan24), 32'd1);
        send_slot(1'b0, 32'h800000, 24, 32, -1);
        check("s2l_aud", aud24, 32'hFF800000);
        check("s2l_chan", 32'(chan24), 32'd0);

        // Truncated right slot (10 bits) then a full left slot
        r0 = rdy24_n;
        e0 = err24_n;
        send_slot(1'b1, 32'hABCDEF, 24, 11, -1);
        check("s3_hold", aud24, 32'hFF800000);
        check("s3_noerr_yet", 32'(err24_n - e0), 32'd0);
        send_slot(1'b0, 32'h00F00F, 24, 32, -1);
        check("s3_err", 32'(err24_n - e0), 32'd1);
        check("s3_cnt", 32'(rdy24_n - r0), 32'd1);
        check("s3_aud", aud24, 32'h0000F00F);
        check("s3_chan", 32'(chan24), 32'd0);

        send_slot(1'b1, 32'h3C3C3C, 24, 32, -1);
        check("s4pre_aud", aud24, 32'h003C3C3C);

        // Reset for 3 cycles after bit 12 of a left slot
        r0 = rdy24_n;
        e0 = err24_n;
        w  = 32'hABCDEF;
        sck_bit(1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) sck_bit(1'b0, w[24 - i]);
        @(negedge s2_clk);
        s2_reset = 1'b1;
        repeat (3) @(negedge s2_clk);
        check("s4_aud", aud24, 32'h0);
        check("s4_chan", 32'(chan24), 32'd0);
        check("s4_rdy", 32'(rdy24), 32'd0);
        check("s4_err", 32'(err24), 32'd0);
        s2_reset = 1'b0;
        for (int i = 13; i < 32; i++) sck_bit(1'b0, (i <= 24) ? w[24 - i] : 1'b0);
        check("s4_nopulse", 32'(rdy24_n - r0), 32'd0);
        check("s4_noerr", 32'(err24_n - e0), 32'd0);
        send_slot(1'b1, 32'h5A5A5A, 24, 32, -1);
        check("s4_cnt", 32'(rdy24_n - r0), 32'd1);
        check("s4_aud2", aud24, 32'h005A5A5A);
        check("s4_chan2", 32'(chan24), 32'd1);

        // Enable dropped mid left slot, raised mid right slot
        r0 = rdy24_n;
        e0 = err24_n;
        send_slot(1'b0, 32'h111111, 24, 32, 9);
        send_slot(1'b1, 32'h222222, 24, 32, 5);
        check("s5_nopulse", 32'(rdy24_n - r0), 32'd0);
        check("s5_noerr", 32'(err24_n - e0), 32'd0);
        check("s5_hold", aud24, 32'h005A5A5A);
        check("s5_holdch", 32'(chan24), 32'd1);
        send_slot(1'b0, 32'h0C0FFE, 24, 32, -1);
        check("s5_cnt", 32'(rdy24_n - r0), 32'd1);
        check("s5_aud", aud24, 32'h000C0FFE);
        check("s5_chan", 32'(chan24), 32'd0);

        // 32-bit instance; the left slot is 34 SCK so all 32 bits precede the next edge
        r0 = rdy32_n;
        send_slot(1'b1, 32'h0, 0, 32, -1);
        send_slot(1'b0, 32'hFFFFFF21, 32, 34, -1);
        send_slot(1'b1, 32'h0, 0, 30, -1);
        check("s6_cnt", 32'(rdy32_n - r0), 32'd1);
        check("s6_aud", aud32, 32'hFFFFFF21);
        check("s6_chan", 32'(chan32), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
